// File: rtl/rx_buffer_rd_sched.sv
// Read-side scheduler for the ping-pong receive buffer: queues half-complete
// events, requests the DSP, and walks RAM port B through the selected half.
module rx_buffer_rd_sched #(
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned HALF_LEN    = 52000,
  parameter int unsigned HALF1_BASE  = 54000,
  parameter int unsigned FINE_LEN    = 4800,
  parameter int unsigned COARSE_STEP = 8
) (
  input  logic              clk_50m,
  input  logic              cfg_rst_n,
  input  logic              half_done_0,
  input  logic              half_done_1,
  input  logic              init_rx_slot,
  input  logic              part_syn_start,
  input  logic              rd_ack,
  input  logic [15:0]       send_step,
  input  logic              data_updated,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_active,
  output logic              read_quest,
  output logic              part_syn_en,
  output logic              burst_done,
  output logic              overrun,
  output logic              cur_half
);

  localparam int unsigned OFS_W = ADDR_W + 1;
  localparam logic [OFS_W-1:0] LAST_OFS = OFS_W'(HALF_LEN - 1);
  localparam logic [OFS_W-1:0] FINE_END = OFS_W'(FINE_LEN - 1);

  typedef enum logic [1:0] {IDLE, REQ, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [OFS_W-1:0] offset, offset_nxt, stride, step_ext;
  logic             half_nxt;
  logic             addr_load;
  logic             fine_end;
  logic             pend0, pend1;
  logic             order1;  // half 1 is the older pending half
  logic             busy;
  logic             new0, new1, ovr0, ovr1;

  assign step_ext = OFS_W'(send_step);
  assign stride   = part_syn_en ? OFS_W'(1) : OFS_W'(COARSE_STEP);
  assign busy     = (state == REQ) || (state == RUN);
  assign ovr0     = half_done_0 && (pend0 || (busy && !cur_half));
  assign ovr1     = half_done_1 && (pend1 || (busy &&  cur_half));
  assign new0     = half_done_0 && !pend0;
  assign new1     = half_done_1 && !pend1;

  always_ff @(posedge clk_50m or negedge cfg_rst_n) begin
    if (!cfg_rst_n)        state <= IDLE;
    else if (init_rx_slot) state <= IDLE;
    else                   state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    offset_nxt = offset;
    half_nxt   = cur_half;
    addr_load  = 1'b0;
    fine_end   = 1'b0;
    read_quest = 1'b0;
    rd_active  = 1'b0;
    burst_done = 1'b0;
    case (state)
      IDLE: begin
        if (pend0 || pend1) begin
          half_nxt  = (pend0 && pend1) ? order1 : pend1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        read_quest = 1'b1;
        if (rd_ack) begin
          offset_nxt = (step_ext > LAST_OFS) ? LAST_OFS : step_ext;
          addr_load  = 1'b1;
          state_nxt  = RUN;
        end
      end
      RUN: begin
        rd_active = 1'b1;
        if (data_updated) begin
          if (part_syn_en && (offset == FINE_END)) begin
            fine_end   = 1'b1;
            offset_nxt = offset + OFS_W'(1);
            addr_load  = 1'b1;
          end else if (offset + stride > LAST_OFS) begin
            state_nxt = DONE;
          end else begin
            offset_nxt = offset + stride;
            addr_load  = 1'b1;
          end
        end
      end
      DONE: begin
        burst_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_50m or negedge cfg_rst_n) begin
    if (!cfg_rst_n) begin
      offset      <= '0;
      rd_addr     <= '0;
      cur_half    <= 1'b0;
      part_syn_en <= 1'b0;
      pend0       <= 1'b0;
      pend1       <= 1'b0;
      order1      <= 1'b0;
      overrun     <= 1'b0;
    end else if (init_rx_slot) begin
      offset      <= '0;
      rd_addr     <= '0;
      cur_half    <= 1'b0;
      part_syn_en <= 1'b0;
      pend0       <= 1'b0;
      pend1       <= 1'b0;
      order1      <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      offset   <= offset_nxt;
      cur_half <= half_nxt;
      if (addr_load)
        rd_addr <= (half_nxt ? ADDR_W'(HALF1_BASE) : '0) + offset_nxt[ADDR_W-1:0];

      if (state == DONE)       part_syn_en <= 1'b0;
      else if (part_syn_start) part_syn_en <= 1'b1;
      else if (fine_end)       part_syn_en <= 1'b0;

      // A refill arriving while DONE clears the same half keeps it pending.
      if (half_done_0)                        pend0 <= 1'b1;
      else if ((state == DONE) && !cur_half)  pend0 <= 1'b0;
      if (half_done_1)                        pend1 <= 1'b1;
      else if ((state == DONE) && cur_half)   pend1 <= 1'b0;

      if (new0 && new1) order1 <= 1'b0;
      else if (new0)    order1 <= pend1;
      else if (new1)    order1 <= !pend0;

      if (ovr0 || ovr1) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_buffer_rd_sched.sv
// Directed bench for rx_buffer_rd_sched: coarse/fine bursts, ordering,
// clamp, overrun, init and asynchronous reset behaviour.
module tb_rx_buffer_rd_sched;

  localparam int unsigned ADDR_W = 17;

  logic              clk_50m = 1'b0;
  logic              cfg_rst_n = 1'b0;
  logic              half_done_0 = 1'b0;
  logic              half_done_1 = 1'b0;
  logic              init_rx_slot = 1'b0;
  logic              part_syn_start = 1'b0;
  logic              rd_ack = 1'b0;
  logic [15:0]       send_step = '0;
  logic              data_updated = 1'b0;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_active, read_quest, part_syn_en, burst_done, overrun, cur_half;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned walk_err;

  always #10 clk_50m = ~clk_50m;

  rx_buffer_rd_sched #(
    .ADDR_W(17), .HALF_LEN(52000), .HALF1_BASE(54000), .FINE_LEN(4800), .COARSE_STEP(8)
  ) dut (
    .clk_50m(clk_50m), .cfg_rst_n(cfg_rst_n),
    .half_done_0(half_done_0), .half_done_1(half_done_1),
    .init_rx_slot(init_rx_slot), .part_syn_start(part_syn_start),
    .rd_ack(rd_ack), .send_step(send_step), .data_updated(data_updated),
    .rd_addr(rd_addr), .rd_active(rd_active), .read_quest(read_quest),
    .part_syn_en(part_syn_en), .burst_done(burst_done), .overrun(overrun),
    .cur_half(cur_half)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic du_pulse();
    data_updated = 1'b1;
    tick();
    data_updated = 1'b0;
  endtask

  task automatic ack(input logic [15:0] step);
    send_step = step;
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"},   32'(rd_addr), 0);
    chk({tag, "_active"}, 32'(rd_active), 0);
    chk({tag, "_rq"},     32'(read_quest), 0);
    chk({tag, "_psen"},   32'(part_syn_en), 0);
    chk({tag, "_bd"},     32'(burst_done), 0);
    chk({tag, "_ovr"},    32'(overrun), 0);
    chk({tag, "_half"},   32'(cur_half), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk_all_zero("reset");
    tick(); tick();
    cfg_rst_n = 1'b1;
    tick();

    // rd_ack / data_updated outside REQ/RUN are ignored
    ack(16'd5);
    du_pulse();
    chk("ack_idle", 32'(rd_active), 0);
    chk("ack_idle_rq", 32'(read_quest), 0);

    // coarse burst, half 0
    half_done_0 = 1'b1; tick(); half_done_0 = 1'b0;
    chk("rq_lat1", 32'(read_quest), 0);
    tick();
    chk("rq_lat2", 32'(read_quest), 1);
    chk("c_half", 32'(cur_half), 0);
    ack(16'd3);
    chk("c_rq_drop", 32'(read_quest), 0);
    chk("c_active", 32'(rd_active), 1);
    chk("c_addr0", 32'(rd_addr), 3);
    walk_err = 0;
    for (int i = 1; i <= 6499; i++) begin
      du_pulse();
      if (int'(rd_addr) != 3 + 8 * i || burst_done !== 1'b0) walk_err++;
    end
    chk("c_walk", walk_err, 0);
    chk("c_last", 32'(rd_addr), 51995);
    du_pulse();
    chk("c_bd", 32'(burst_done), 1);
    chk("c_bd_active", 32'(rd_active), 0);
    tick();
    chk("c_bd_once", 32'(burst_done), 0);
    tick();
    chk("c_pend0_clr", 32'(read_quest), 0);

    // fine then coarse, half 1
    half_done_1 = 1'b1; tick(); half_done_1 = 1'b0;
    part_syn_start = 1'b1; tick(); part_syn_start = 1'b0;
    chk("f_psen", 32'(part_syn_en), 1);
    chk("f_rq", 32'(read_quest), 1);
    chk("f_half", 32'(cur_half), 1);
    ack(16'd0);
    chk("f_addr0", 32'(rd_addr), 54000);
    walk_err = 0;
    for (int i = 1; i <= 4799; i++) begin
      du_pulse();
      if (int'(rd_addr) != 54000 + i || part_syn_en !== 1'b1) walk_err++;
    end
    chk("f_walk", walk_err, 0);
    chk("f_last", 32'(rd_addr), 58799);
    du_pulse();
    chk("f_exit_addr", 32'(rd_addr), 58800);
    chk("f_exit_psen", 32'(part_syn_en), 0);
    du_pulse();
    chk("f_coarse1", 32'(rd_addr), 58808);
    walk_err = 0;
    for (int i = 1; i <= 5898; i++) begin
      du_pulse();
      if (int'(rd_addr) != 58808 + 8 * i || burst_done !== 1'b0) walk_err++;
    end
    chk("f_walk2", walk_err, 0);
    chk("f_end_addr", 32'(rd_addr), 105992);
    du_pulse();
    chk("f_bd", 32'(burst_done), 1);
    tick(); tick();
    chk("f_idle", 32'(read_quest), 0);

    // both halves pending: half 1 first
    half_done_1 = 1'b1; tick(); half_done_1 = 1'b0;
    tick();
    half_done_0 = 1'b1; tick(); half_done_0 = 1'b0;
    chk("b_half1", 32'(cur_half), 1);
    chk("b_rq", 32'(read_quest), 1);
    chk("b_no_ovr", 32'(overrun), 0);
    ack(16'd51990);
    chk("b_addr0", 32'(rd_addr), 105990);
    du_pulse();
    chk("b_addr1", 32'(rd_addr), 105998);
    du_pulse();
    chk("b_bd", 32'(burst_done), 1);
    chk("b_bd_half", 32'(cur_half), 1);
    tick();
    chk("b_idle_rq", 32'(read_quest), 0);
    tick();
    chk("b_rq_m3", 32'(read_quest), 1);
    chk("b_half0", 32'(cur_half), 0);

    // send_step clamp on half 0
    ack(16'd60000);
    chk("clamp_addr", 32'(rd_addr), 51999);
    chk("clamp_active", 32'(rd_active), 1);
    du_pulse();
    chk("clamp_bd", 32'(burst_done), 1);
    tick(); tick();
    chk("clamp_idle", 32'(read_quest), 0);

    // overrun, then init clears it
    half_done_0 = 1'b1; tick(); half_done_0 = 1'b0;
    tick();
    chk("o_rq", 32'(read_quest), 1);
    half_done_0 = 1'b1; tick(); half_done_0 = 1'b0;
    chk("o_ovr", 32'(overrun), 1);
    chk("o_rq_hold", 32'(read_quest), 1);
    init_rx_slot = 1'b1; tick(); init_rx_slot = 1'b0;
    chk("o_init_ovr", 32'(overrun), 0);
    chk("o_init_rq", 32'(read_quest), 0);
    tick();
    chk("o_pend_clr", 32'(read_quest), 0);

    // asynchronous reset mid-RUN
    half_done_1 = 1'b1; tick(); half_done_1 = 1'b0;
    tick();
    ack(16'd100);
    chk("r_addr", 32'(rd_addr), 54100);
    part_syn_start = 1'b1; tick(); part_syn_start = 1'b0;
    chk("r_psen", 32'(part_syn_en), 1);
    cfg_rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    tick();
    chk("rst_no_bd", 32'(burst_done), 0);
    cfg_rst_n = 1'b1;
    tick(); tick();
    chk("rst_pend_clr", 32'(read_quest), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
